// File: rtl/simple_comparator.sv
// simple_comparator: registered equality / magnitude comparator for two
// WIDTH-bit operands. This is a leaf compare stage with one cycle of latency
// and a simple valid qualifier.
// Optional match/mismatch statistics are built when SIMPLE_COMPARATOR_STATS_EN
// is defined.
module simple_comparator #(
  parameter int unsigned WIDTH  = 1,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SIMPLE_COMPARATOR_STATS_EN
  input  logic             stats_clr,
  output logic [15:0]      mismatch_cnt,
  output logic [15:0]      match_cnt,
`endif
  input  logic             in_valid,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic             res,
  output logic             lt,
  output logic             gt,
  output logic             out_valid
);

  logic [WIDTH-1:0] sign_flip;
  logic [WIDTH-1:0] a_ord;
  logic [WIDTH-1:0] b_ord;
  logic             a_eq_b;
  logic             a_lt_b;
  logic             a_gt_b;

  // Inverting the MSB maps two's-complement order onto unsigned order,
  // so a single unsigned comparator serves both modes.
  always_comb begin
    sign_flip            = '0;
    sign_flip[WIDTH-1]   = SIGNED;
    a_ord                = input_a ^ sign_flip;
    b_ord                = input_b ^ sign_flip;
    a_eq_b               = (input_a == input_b);
    a_lt_b               = (a_ord < b_ord);
    a_gt_b               = (a_ord > b_ord);
  end

  // Capture the flags only on accepted operands; otherwise hold them and drop out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      res       <= 1'b0;
      lt        <= 1'b0;
      gt        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        res <= a_eq_b;
        lt  <= a_lt_b;
        gt  <= a_gt_b;
      end
    end
  end

`ifdef SIMPLE_COMPARATOR_STATS_EN
  // Saturating counters of accepted compares. A clear beats an increment.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      match_cnt    <= '0;
      mismatch_cnt <= '0;
    end else if (in_valid) begin
      if (a_eq_b) begin
        if (match_cnt != '1) match_cnt <= match_cnt + 16'd1;
      end else begin
        if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_simple_comparator.sv
// Testbench for simple_comparator. It instantiates six width/signedness
// variants that share one set of operands. Each variant uses the low bits.
module tb_simple_comparator;

  localparam logic [2:0] E = 3'b100;  // {res, lt, gt}
  localparam logic [2:0] L = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Z = 3'b000;

  // Instance index: 0=u8, 1=s8, 2=u4, 3=s4, 4=u1, 5=s1
  typedef struct {
    logic [7:0]      a;
    logic [7:0]      b;
    logic [5:0][2:0] e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic stats_clr;
  logic [7:0] a8;
  logic [7:0] b8;
  logic [5:0] res_o, lt_o, gt_o, ov_o;
  logic [5:0][15:0] mc, mm;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  simple_comparator #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
    .clk(clk), .rst(rst),
`ifdef SIMPLE_COMPARATOR_STATS_EN
    .stats_clr(stats_clr), .mismatch_cnt(mm[0]), .match_cnt(mc[0]),
`endif
    .in_valid(in_valid), .input_a(a8), .input_b(b8),
    .res(res_o[0]), .lt(lt_o[0]), .gt(gt_o[0]), .out_valid(ov_o[0]));

  simple_comparator #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
    .clk(clk), .rst(rst),
`ifdef SIMPLE_COMPARATOR_STATS_EN
    .stats_clr(stats_clr), .mismatch_cnt(mm[1]), .match_cnt(mc[1]),
`endif
    .in_valid(in_valid), .input_a(a8), .input_b(b8),
    .res(res_o[1]), .lt(lt_o[1]), .gt(gt_o[1]), .out_valid(ov_o[1]));

  simple_comparator #(.WIDTH(4), .SIGNED(1'b0)) u_u4 (
    .clk(clk), .rst(rst),
`ifdef SIMPLE_COMPARATOR_STATS_EN
    .stats_clr(stats_clr), .mismatch_cnt(mm[2]), .match_cnt(mc[2]),
`endif
    .in_valid(in_valid), .input_a(a8[3:0]), .input_b(b8[3:0]),
    .res(res_o[2]), .lt(lt_o[2]), .gt(gt_o[2]), .out_valid(ov_o[2]));

  simple_comparator #(.WIDTH(4), .SIGNED(1'b1)) u_s4 (
    .clk(clk), .rst(rst),
`ifdef SIMPLE_COMPARATOR_STATS_EN
    .stats_clr(stats_clr), .mismatch_cnt(mm[3]), .match_cnt(mc[3]),
`endif
    .in_valid(in_valid), .input_a(a8[3:0]), .input_b(b8[3:0]),
    .res(res_o[3]), .lt(lt_o[3]), .gt(gt_o[3]), .out_valid(ov_o[3]));

  simple_comparator #(.WIDTH(1), .SIGNED(1'b0)) u_u1 (
    .clk(clk), .rst(rst),
`ifdef SIMPLE_COMPARATOR_STATS_EN
    .stats_clr(stats_clr), .mismatch_cnt(mm[4]), .match_cnt(mc[4]),
`endif
    .in_valid(in_valid), .input_a(a8[0:0]), .input_b(b8[0:0]),
    .res(res_o[4]), .lt(lt_o[4]), .gt(gt_o[4]), .out_valid(ov_o[4]));

  simple_comparator #(.WIDTH(1), .SIGNED(1'b1)) u_s1 (
    .clk(clk), .rst(rst),
`ifdef SIMPLE_COMPARATOR_STATS_EN
    .stats_clr(stats_clr), .mismatch_cnt(mm[5]), .match_cnt(mc[5]),
`endif
    .in_valid(in_valid), .input_a(a8[0:0]), .input_b(b8[0:0]),
    .res(res_o[5]), .lt(lt_o[5]), .gt(gt_o[5]), .out_valid(ov_o[5]));

`ifndef SIMPLE_COMPARATOR_STATS_EN
  assign mc = '0;
  assign mm = '0;
`endif

  function automatic logic [5:0][2:0] mk(input logic [2:0] u8, input logic [2:0] s8,
                                         input logic [2:0] u4, input logic [2:0] s4,
                                         input logic [2:0] u1, input logic [2:0] s1);
    logic [5:0][2:0] r;
    r[0] = u8; r[1] = s8; r[2] = u4; r[3] = s4; r[4] = u1; r[5] = s1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_trip(input string nm, input int k, input logic [2:0] exp);
    chk($sformatf("%s inst%0d res/lt/gt", nm, k), {13'd0, res_o[k], lt_o[k], gt_o[k]}, {13'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{8'h00, 8'h00, mk(E, E, E, E, E, E)};
    tbl[1] = '{8'h00, 8'h01, mk(L, L, L, L, L, G)};
    tbl[2] = '{8'h01, 8'h00, mk(G, G, G, G, G, L)};
    tbl[3] = '{8'h01, 8'h01, mk(E, E, E, E, E, E)};
    tbl[4] = '{8'h08, 8'h01, mk(G, G, G, L, L, G)};
    tbl[5] = '{8'hFF, 8'h00, mk(G, L, G, L, G, L)};
    tbl[6] = '{8'hFF, 8'hFF, mk(E, E, E, E, E, E)};
    tbl[7] = '{8'h03, 8'h05, mk(L, L, L, L, E, E)};
    tbl[8] = '{8'h80, 8'h7F, mk(G, L, L, G, L, G)};
    tbl[9] = '{8'h39, 8'h93, mk(L, G, G, L, E, E)};

    // Reset held for two cycles while a valid compare is offered; it must be discarded.
    rst = 1'b1; in_valid = 1'b1; stats_clr = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      step();
      for (int k = 0; k < 6; k++) chk_trip($sformatf("reset%0d", c), k, Z);
      chk("reset out_valid", {10'd0, ov_o}, 16'd0);
    end

    // No compare yet: all flags still 0.
    rst = 1'b0; in_valid = 1'b0;
    step();
    for (int k = 0; k < 6; k++) chk_trip("pre-first", k, Z);
    chk("pre-first out_valid", {15'd0, ov_o[0]}, 16'd0);

    // The first compare after reset.
    in_valid = 1'b1;
    step();
    chk_trip("post-reset", 0, E);
    chk("post-reset out_valid", {15'd0, ov_o[0]}, 16'd1);

    // Back-to-back table vectors.
    foreach (tbl[i]) begin
      a8 = tbl[i].a; b8 = tbl[i].b; in_valid = 1'b1;
      step();
      chk($sformatf("vec%0d out_valid", i), {10'd0, ov_o}, 16'h003F);
      for (int k = 0; k < 6; k++) chk_trip($sformatf("vec%0d", i), k, tbl[i].e[k]);
    end

    // Hold: flags keep the last result while in_valid is low.
    a8 = 8'h03; b8 = 8'h05; in_valid = 1'b1;
    step();
    chk_trip("hold-load", 2, L);
    in_valid = 1'b0; a8 = 8'h09; b8 = 8'h09;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin a8 = 'x; b8 = 'x; end
      step();
      chk_trip($sformatf("hold%0d", c), 2, L);
      chk($sformatf("hold%0d out_valid", c), {15'd0, ov_o[2]}, 16'd0);
    end

    // Reset in the middle of a stream, then resume.
    a8 = 8'h3C; b8 = 8'h3C; in_valid = 1'b1; rst = 1'b1;
    step();
    chk_trip("midrst", 0, Z);
    chk("midrst out_valid", {15'd0, ov_o[0]}, 16'd0);
    rst = 1'b0; a8 = 8'h03; b8 = 8'h05;
    step();
    chk_trip("midrst-resume", 0, L);
    chk("midrst-resume out_valid", {15'd0, ov_o[0]}, 16'd1);

`ifdef SIMPLE_COMPARATOR_STATS_EN
    stats_clr = 1'b1; in_valid = 1'b0;
    step();
    chk("stats clr match", mc[0], 16'd0);
    chk("stats clr mismatch", mm[0], 16'd0);
    stats_clr = 1'b0; in_valid = 1'b1;
    a8 = 8'h01; b8 = 8'h01; step();
    chk("stats first match", mc[0], 16'd1);
    a8 = 8'h02; b8 = 8'h03; step();
    a8 = 8'h04; b8 = 8'h04; step();
    a8 = 8'h05; b8 = 8'h00; step();
    a8 = 8'h07; b8 = 8'h07; step();
    in_valid = 1'b0; step();
    chk("stats match", mc[0], 16'd3);
    chk("stats mismatch", mm[0], 16'd2);
    stats_clr = 1'b1; in_valid = 1'b1; a8 = 8'h01; b8 = 8'h01;
    step();
    chk("stats clr-vs-inc match", mc[0], 16'd0);
    chk("stats clr-vs-inc mismatch", mm[0], 16'd0);
    stats_clr = 1'b0;
    repeat (65535) @(posedge clk);
    #1;
    chk("stats reach sat", mc[0], 16'hFFFF);
    step();
    chk("stats sat stick", mc[0], 16'hFFFF);
    chk("stats sat mismatch", mm[0], 16'd0);
    in_valid = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
